mips_trace_monitor: RTL and testbench
=====================================

// Module: mips_trace_monitor
// PURPOSE
//  Synthesizable retire-trace monitor for the MIPS CPU family (single-cycle and successors).
//  Decodes each retiring instruction into a class, keeps saturating per-class counters,
//  and buffers {cycle, pc, class, wd} trace records in a first-word-fall-through FIFO.
//  A host or bench drains the FIFO with a valid/ready handshake.
//  Sits beside the CPU core and taps pc/opcode/funct/rfile_wd, so traces no longer need $display.
// PARAMETERS
//  PC_W    32  width of pc and trace_pc
//  DATA_W  32  width of rfile_wd and trace_wd
//  DEPTH   16  trace FIFO entries; power of two, >=2
//  CNT_W   32  width of each class counter, cycle counter and trace_cycle
// PORTS
//  clk          in   1             clock, rising edge
//  rst          in   1             synchronous reset, active-high
//  mon_en       in   1             1 = monitoring enabled
//  retire       in   1             one instruction retires this cycle
//  pc           in   PC_W          PC of the retiring instruction
//  opcode       in   6             instr[31:26]
//  funct        in   6             instr[5:0]
//  rfile_wd     in   DATA_W        register-file write data this cycle
//  trace_valid  out  1             FIFO head valid
//  trace_ready  in   1             consumer accepts head
//  trace_cycle  out  CNT_W         cycle index of head record
//  trace_pc     out  PC_W          PC of head record
//  trace_class  out  4             class of head record
//  trace_wd     out  DATA_W        wd of head record
//  cnt_sel      in   4             counter select
//  cnt_value    out  CNT_W         selected counter, registered
//  cnt_clear    in   1             clear counters and overflow
//  cycle_count  out  CNT_W         cycles since reset release
//  fifo_level   out  $clog2(DEPTH)+1  FIFO occupancy
//  overflow     out  1             sticky: a record was dropped
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, counters 0. rst mid-operation discards FIFO contents.
//  - cycle_count: 0 in the first cycle after rst falls, then +1 every cycle; wraps at 2^CNT_W.
//  - Class map (op==0 uses funct): 32->0 ADD, 34->1 SUB, 36->2 AND, 37->3 OR, 42->4 SLT,
//    any other funct->9 R_OTHER; op 35->5 LW, 43->6 SW, 4->7 BEQ, 2->8 J; any other op->10 UNKNOWN.
//  - Capture: a record is captured when retire && mon_en are high at an edge.
//    The record holds {cycle_count, pc, class, rfile_wd} sampled at that edge.
//  - Counting: each capture increments counter[class] and the total counter (cnt_sel=15).
//    Counters saturate at all-ones. cnt_sel 11..14 read 0.
//  - cnt_value = counter[cnt_sel], registered, 1-cycle latency.
//  - cnt_clear zeroes all counters and overflow. It has priority over a simultaneous capture:
//    that capture is not counted but is still pushed. FIFO and cycle_count are unaffected.
//  - FIFO: first-word-fall-through. trace_valid = (level != 0). Head fields are stable while
//    valid && !ready. Pop on trace_valid && trace_ready.
//  - Latency: a record captured at edge t is visible on trace_* after edge t when the FIFO was empty.
//  - Full: a capture while level == DEPTH and no pop in the same cycle is dropped.
//    overflow is set (sticky) and the record is still counted.
//  - Full with a simultaneous pop: the push is accepted and level stays DEPTH.
//  - Empty with a simultaneous push: no pop occurs; valid rises the next cycle.
//  - Pointers wrap modulo DEPTH. fifo_level is exact, 0..DEPTH.
//  - mon_en low: no capture or count; draining continues.
// TESTING
//  1 Release rst at cycle 0; retire ADD(op0,f32) pc=0 wd=5 at cycle 0 ->
//    next cycle trace_valid=1, cycle=0, pc=0, class=0, wd=5; cnt_sel=0 gives 1 one cycle later.
//  2 Retire LW, SW, BEQ, J, op=8, R f=39 on consecutive cycles ->
//    classes 5, 6, 7, 8, 10, 9 pop in order; total counter = 6.
//  3 Set trace_ready=0 and retire DEPTH+3 instructions -> fifo_level=16, overflow=1,
//    total=19; drained records are the first 16 in PC order.
//  4 With FIFO full, pop and push in the same cycle -> level stays 16, and the new
//    record appears as the last entry.
//  5 Assert cnt_clear with a retiring SUB -> all counters 0, overflow 0, SUB record still in FIFO.
//  6 Assert rst with 5 records buffered -> trace_valid=0, level=0, counters 0,
//    cycle_count=0 after release.

Source files
------------

// File: rtl/mips_trace_monitor.sv
// Retire-trace monitor for MIPS cores: classifies retiring instructions, keeps saturating
// per-class counters and buffers {cycle, pc, class, wd} records in a FWFT FIFO.
module mips_trace_monitor #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mon_en,
   input  logic                     retire,
   input  logic [PC_W-1:0]          pc,
   input  logic [5:0]               opcode,
   input  logic [5:0]               funct,
   input  logic [DATA_W-1:0]        rfile_wd,
   output logic                     trace_valid,
   input  logic                     trace_ready,
   output logic [CNT_W-1:0]         trace_cycle,
   output logic [PC_W-1:0]          trace_pc,
   output logic [3:0]               trace_class,
   output logic [DATA_W-1:0]        trace_wd,
   input  logic [3:0]               cnt_sel,
   output logic [CNT_W-1:0]         cnt_value,
   input  logic                     cnt_clear,
   output logic [CNT_W-1:0]         cycle_count,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow
);

   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW + 1;
   localparam int NCLS = 11;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef enum logic [3:0] {
      CL_ADD = 4'd0, CL_SUB = 4'd1, CL_AND = 4'd2, CL_OR = 4'd3, CL_SLT = 4'd4,
      CL_LW = 4'd5, CL_SW = 4'd6, CL_BEQ = 4'd7, CL_J = 4'd8,
      CL_R_OTHER = 4'd9, CL_UNKNOWN = 4'd10
   } class_e;

   typedef struct packed {
      logic [CNT_W-1:0]  cyc;
      logic [PC_W-1:0]   pc;
      class_e            cls;
      logic [DATA_W-1:0] wd;
   } rec_t;

   function automatic class_e decode(input logic [5:0] op, input logic [5:0] fn);
      class_e c;
      c = CL_UNKNOWN;
      case (op)
         6'd0: begin
            case (fn)
               6'd32:   c = CL_ADD;
               6'd34:   c = CL_SUB;
               6'd36:   c = CL_AND;
               6'd37:   c = CL_OR;
               6'd42:   c = CL_SLT;
               default: c = CL_R_OTHER;
            endcase
         end
         6'd35:   c = CL_LW;
         6'd43:   c = CL_SW;
         6'd4:    c = CL_BEQ;
         6'd2:    c = CL_J;
         default: c = CL_UNKNOWN;
      endcase
      return c;
   endfunction

   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] cnt_q [NCLS];
   logic [CNT_W-1:0] cnt_d [NCLS];
   logic [CNT_W-1:0] total_q, total_d;
   logic [CNT_W-1:0] cnt_value_q, cnt_value_d;
   rec_t             mem_q [DEPTH];
   rec_t             rec_in, head;
   logic             capture, pop, push_ok, drop;

   assign capture = retire && mon_en;
   assign pop     = (level_q != '0) && trace_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok = capture && ((level_q != FULL_LVL) || pop);
   assign drop    = capture && !push_ok;
   assign rec_in  = '{cyc: cycle_q, pc: pc, cls: decode(opcode, funct), wd: rfile_wd};

   // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
   always_comb begin
      cycle_d    = cycle_q + CNT_W'(1);
      wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d    = level_q;
      if (push_ok && !pop)      level_d = level_q + LW'(1);
      else if (!push_ok && pop) level_d = level_q - LW'(1);
      overflow_d = cnt_clear ? 1'b0 : (overflow_q || drop);
   end

   always_comb begin
      cnt_d   = cnt_q;
      total_d = total_q;
      if (cnt_clear) begin
         for (int i = 0; i < NCLS; i++) cnt_d[i] = '0;
         total_d = '0;
      end else if (capture) begin
         for (int i = 0; i < NCLS; i++) begin
            if (rec_in.cls == 4'(i) && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
         if (total_q != '1) total_d = total_q + CNT_W'(1);
      end
   end

   always_comb begin
      cnt_value_d = '0;
      if (cnt_sel == 4'd15) cnt_value_d = total_q;
      for (int i = 0; i < NCLS; i++) begin
         if (cnt_sel == 4'(i)) cnt_value_d = cnt_q[i];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         total_q     <= '0;
         cnt_value_q <= '0;
         for (int i = 0; i < NCLS; i++) cnt_q[i] <= '0;
      end else begin
         cycle_q     <= cycle_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         total_q     <= total_d;
         cnt_value_q <= cnt_value_d;
         cnt_q       <= cnt_d;
      end
   end

   // NOTE: storage is not reset; pointers and level decide validity and outputs are gated.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= rec_in;
   end

   assign head        = mem_q[rd_ptr_q];
   assign trace_valid = (level_q != '0);
   assign trace_cycle = trace_valid ? head.cyc : '0;
   assign trace_pc    = trace_valid ? head.pc  : '0;
   assign trace_class = trace_valid ? head.cls : 4'd0;
   assign trace_wd    = trace_valid ? head.wd  : '0;
   assign cnt_value   = cnt_value_q;
   assign cycle_count = cycle_q;
   assign fifo_level  = level_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_mips_trace_monitor.sv
// Directed bench for mips_trace_monitor: decode table plus multi-cycle FIFO/counter sequences.
module tb_mips_trace_monitor;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mon_en = 1'b1;
   logic        retire = 1'b0;
   logic [31:0] pc = '0;
   logic [5:0]  opcode = '0;
   logic [5:0]  funct = '0;
   logic [31:0] rfile_wd = '0;
   logic        trace_valid;
   logic        trace_ready = 1'b0;
   logic [31:0] trace_cycle;
   logic [31:0] trace_pc;
   logic [3:0]  trace_class;
   logic [31:0] trace_wd;
   logic [3:0]  cnt_sel = '0;
   logic [31:0] cnt_value;
   logic        cnt_clear = 1'b0;
   logic [31:0] cycle_count;
   logic [4:0]  fifo_level;
   logic        overflow;

   mips_trace_monitor #(.PC_W(32), .DATA_W(32), .DEPTH(DEPTH), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .mon_en(mon_en), .retire(retire), .pc(pc),
      .opcode(opcode), .funct(funct), .rfile_wd(rfile_wd),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_cycle(trace_cycle), .trace_pc(trace_pc), .trace_class(trace_class),
      .trace_wd(trace_wd), .cnt_sel(cnt_sel), .cnt_value(cnt_value),
      .cnt_clear(cnt_clear), .cycle_count(cycle_count), .fifo_level(fifo_level),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference cycle counter: 0 while in reset, then +1 per edge.
   logic [31:0] tb_cyc = '0;
   always @(posedge clk) tb_cyc <= rst ? 32'd0 : tb_cyc + 32'd1;

   typedef struct {
      logic [31:0] cyc;
      logic [31:0] pc;
      logic [3:0]  cls;
      logic [31:0] wd;
   } rec_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic [3:0] cls;
   } vec_t;

   rec_t exp_q[$];
   vec_t vecs[10];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_retire(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] p,
                            input logic [31:0] w, input logic [3:0] cls, input bit keep);
      retire = 1'b1; opcode = op; funct = fn; pc = p; rfile_wd = w;
      if (keep) exp_q.push_back('{cyc: tb_cyc, pc: p, cls: cls, wd: w});
      step();
      retire = 1'b0;
   endtask

   task automatic read_cnt(input logic [3:0] sel, input logic [31:0] exp, input string name);
      cnt_sel = sel;
      step();
      check(name, 64'(cnt_value), 64'(exp));
   endtask

   task automatic drain(input int n);
      rec_t r;
      for (int i = 0; i < n; i++) begin
         r = exp_q[0];
         check("drain_valid", 64'(trace_valid), 64'd1);
         check("drain_pc",    64'(trace_pc),    64'(r.pc));
         check("drain_class", 64'(trace_class), 64'(r.cls));
         check("drain_wd",    64'(trace_wd),    64'(r.wd));
         check("drain_cycle", 64'(trace_cycle), 64'(r.cyc));
         trace_ready = 1'b1;
         step();
         trace_ready = 1'b0;
         void'(exp_q.pop_front());
         check("drain_level", 64'(fifo_level), 64'(exp_q.size()));
      end
   endtask

   initial begin
      logic [31:0] head_pc;
      int total;

      vecs[0] = '{op: 6'd35, fn: 6'd0,  cls: 4'd5};
      vecs[1] = '{op: 6'd43, fn: 6'd0,  cls: 4'd6};
      vecs[2] = '{op: 6'd4,  fn: 6'd0,  cls: 4'd7};
      vecs[3] = '{op: 6'd2,  fn: 6'd0,  cls: 4'd8};
      vecs[4] = '{op: 6'd8,  fn: 6'd32, cls: 4'd10};
      vecs[5] = '{op: 6'd0,  fn: 6'd39, cls: 4'd9};
      vecs[6] = '{op: 6'd0,  fn: 6'd34, cls: 4'd1};
      vecs[7] = '{op: 6'd0,  fn: 6'd36, cls: 4'd2};
      vecs[8] = '{op: 6'd0,  fn: 6'd37, cls: 4'd3};
      vecs[9] = '{op: 6'd0,  fn: 6'd42, cls: 4'd4};

      // Reset state
      step(); step();
      check("rst_valid", 64'(trace_valid), 64'd0);
      check("rst_level", 64'(fifo_level),  64'd0);
      check("rst_cycle", 64'(cycle_count), 64'd0);
      check("rst_ovf",   64'(overflow),    64'd0);
      check("rst_cnt",   64'(cnt_value),   64'd0);
      check("rst_pc",    64'(trace_pc),    64'd0);

      // 1: ADD retiring in the first cycle after reset release
      rst = 1'b0;
      cnt_sel = 4'd0;
      do_retire(6'd0, 6'd32, 32'h0, 32'd5, 4'd0, 1'b1);
      check("t1_valid", 64'(trace_valid), 64'd1);
      check("t1_cycle", 64'(trace_cycle), 64'd0);
      check("t1_pc",    64'(trace_pc),    64'd0);
      check("t1_class", 64'(trace_class), 64'd0);
      check("t1_wd",    64'(trace_wd),    64'd5);
      check("t1_cnt_lat", 64'(cnt_value), 64'd0);
      step();
      check("t1_cnt_add", 64'(cnt_value), 64'd1);
      check("t1_cyc_cnt", 64'(cycle_count), 64'(tb_cyc));
      // Head is held while not ready
      check("t1_hold_wd", 64'(trace_wd), 64'd5);
      drain(1);
      total = 1;

      // 2: decode table, back-to-back retires then in-order drain
      for (int i = 0; i < 10; i++) begin
         do_retire(vecs[i].op, vecs[i].fn, 32'h100 + 32'(4 * i), 32'(3 * i + 1), vecs[i].cls, 1'b1);
         total++;
      end
      check("t2_level", 64'(fifo_level), 64'd10);
      read_cnt(4'd15, 32'(total), "t2_total");
      read_cnt(4'd5,  32'd1, "t2_cnt_lw");
      read_cnt(4'd12, 32'd0, "t2_cnt_unused");
      read_cnt(4'd0,  32'd1, "t2_cnt_add");
      drain(10);

      // mon_en low: no capture, no count
      mon_en = 1'b0;
      do_retire(6'd0, 6'd32, 32'h500, 32'd9, 4'd0, 1'b0);
      mon_en = 1'b1;
      check("men_level", 64'(fifo_level), 64'd0);
      read_cnt(4'd15, 32'(total), "men_total");

      // 3: overflow with no consumer
      for (int i = 0; i < DEPTH + 3; i++) begin
         do_retire(6'd0, 6'd32, 32'h1000 + 32'(4 * i), 32'(i), 4'd0, i < DEPTH);
         total++;
      end
      check("t3_level", 64'(fifo_level), 64'd16);
      check("t3_ovf",   64'(overflow),   64'd1);
      read_cnt(4'd15, 32'(total), "t3_total");

      // 4: full FIFO with simultaneous pop and push
      head_pc = exp_q[0].pc;
      check("t4_head", 64'(trace_pc), 64'(head_pc));
      trace_ready = 1'b1;
      do_retire(6'd43, 6'd0, 32'h2000, 32'h77, 4'd6, 1'b1);
      trace_ready = 1'b0;
      void'(exp_q.pop_front());
      total++;
      check("t4_level", 64'(fifo_level), 64'd16);
      check("t4_ovf",   64'(overflow),   64'd1);
      drain(16);
      check("t4_empty", 64'(trace_valid), 64'd0);

      // 5: clear beats a simultaneous SUB capture, which is still buffered
      cnt_clear = 1'b1;
      do_retire(6'd0, 6'd34, 32'h300, 32'd7, 4'd1, 1'b1);
      cnt_clear = 1'b0;
      check("t5_ovf",   64'(overflow),   64'd0);
      check("t5_level", 64'(fifo_level), 64'd1);
      check("t5_class", 64'(trace_class), 64'd1);
      read_cnt(4'd1,  32'd0, "t5_cnt_sub");
      read_cnt(4'd15, 32'd0, "t5_total");
      do_retire(6'd0, 6'd32, 32'h304, 32'd8, 4'd0, 1'b1);
      read_cnt(4'd15, 32'd1, "t5_total_after");

      // 6: reset with 5 records buffered
      for (int i = 0; i < 3; i++) do_retire(6'd35, 6'd0, 32'h400 + 32'(4 * i), 32'(i), 4'd5, 1'b1);
      check("t6_level_pre", 64'(fifo_level), 64'd5);
      rst = 1'b1;
      step();
      exp_q.delete();
      check("t6_valid", 64'(trace_valid), 64'd0);
      check("t6_level", 64'(fifo_level),  64'd0);
      check("t6_cycle", 64'(cycle_count), 64'd0);
      check("t6_cnt",   64'(cnt_value),   64'd0);
      check("t6_wd",    64'(trace_wd),    64'd0);
      rst = 1'b0;
      read_cnt(4'd5, 32'd0, "t6_cnt_lw");
      check("t6_cyc_run", 64'(cycle_count), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
